real_pow_sched: RTL and testbench
=================================

Name: real_pow_sched

Overview:
- Time-multiplexes one shared real_pow evaluator (out = in**powf) among NREQ requesters.
- Round-robin arbitration picks one requester.
- Latched operands drive the evaluator for SETTLE clock edges, then the result is captured.
- A tagged completion pulse is returned, along with a domain-error flag.
- Sits between mLingua behavioural consumers (e.g. gain/law calculators) and a single real_pow instance, so only one pow is ever evaluated per slot.

Parameters:
- NREQ, 4: number of requesters; must be >= 2.
- SETTLE, 2: clock edges operands are held on the evaluator before its output is sampled; must be >= 1.
- IDW, $clog2(NREQ): width of the requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- base  input  real[NREQ]  per-requester base operand.
- expo  input  real[NREQ]  per-requester exponent operand.
- ack  output  NREQ  one-cycle pulse: request accepted and operands latched.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse: result valid.
- done_id  output  IDW  index of the requester owning the result.
- result  output  real  captured evaluator output.
- dom_err  output  1  qualifies done: operands were outside the real domain.
- pow_in  output  real  base driven to the evaluator.
- pow_powf  output  real  exponent driven to the evaluator.
- pow_out  input  real  evaluator output.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE, rr pointer = 0, ack = 0, busy = 0, done = 0, done_id = 0, dom_err = 0.
  - result = 0.0, pow_in = 0.0, pow_powf = 0.0.
- FSM states: IDLE, RUN.
- IDLE, at an edge with any req high:
  - Winner w = first set req bit scanning from the rr pointer upward, wrapping modulo NREQ.
  - ack[w] <= 1; pow_in <= base[w]; pow_powf <= expo[w]; latch w and the domain check.
  - busy <= 1; cnt <= SETTLE-1; state <= RUN; pointer <= (w+1) mod NREQ.
- IDLE, at an edge with no req: nothing changes; ack, done and busy stay 0.
- RUN, at each edge:
  - ack <= 0.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: result <= (err ? 0.0 : pow_out); dom_err <= err; done <= 1; done_id <= w; busy <= 0; state <= IDLE.
- done and dom_err are single-cycle pulses. done clears at the next edge. result and done_id hold until the next completion.
- Timing: edge E0 grants. ack is visible E0..E1. done is visible after edge E0+SETTLE. Throughput is one operation per SETTLE+1 edges.
- A requester holds req, base and expo stable until it sees ack. req still high in the cycle after ack counts as a new request.
- req is ignored during RUN. No queueing; pending requests are arbitrated at the first IDLE edge.
- pow_in and pow_powf hold their last values while IDLE. No X or NaN is driven after reset.
- Domain error is latched at grant:
  - (base < 0.0 and expo != $floor(expo)), or
  - (base == 0.0 and expo < 0.0).
- Negative base with an integer exponent is legal (e.g. -2.0**3.0 = -8.0).
- Reset during RUN aborts the operation: no done pulse, busy = 0 after the edge, pointer back to 0.
- Simultaneous requests are resolved purely by the rr pointer. Starvation-free: every held request is served within NREQ grants.

Decomposition:
- Package real_pow_sched_pkg holds:
  - state_t enum {IDLE, RUN};
  - function pow_dom_err(real b, real e) returning bit;
  - localparam helper for IDW.
- Sub-module rr_pick (combinational): inputs req[NREQ] and ptr[IDW]; outputs any and grant index.
- real_pow stays external; the wrapper or testbench connects pow_in / pow_powf / pow_out to it.

Test Plan:
- Single op: req[1]=1, base=2.0, expo=10.0, SETTLE=2 → ack[1] after E0; after E2 done=1, done_id=1, result=1024.0, dom_err=0, busy=0.
- Contention: req=4'b1111 held, each requester drops req after its ack, then re-raises it → grants in order 0,1,2,3,0,…; one done per 3 edges; each done_id matches its grant.
- Domain:
  - base=-8.0, expo=0.5 → dom_err=1, result=0.0.
  - base=0.0, expo=-1.0 → dom_err=1.
  - base=-2.0, expo=3.0 → result=-8.0, dom_err=0.
- Late arrival: req[0] rises during RUN serving requester 2 → ignored until IDLE; next grant is 3 if req[3] is pending, else 0.
- Reset mid-op: rst asserted one edge after grant → no done, busy=0, outputs at reset values; next simultaneous req=4'b0110 grants 1.
- SETTLE=1 build: base=3.0, expo=2.0 → ack after E0, done after E1, result=9.0.

Source files
------------

// File: rtl/real_pow_sched_pkg.sv
// Shared types and helpers for the round-robin real_pow time-multiplexer.
package real_pow_sched_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  // Index width that stays at least one bit wide even for tiny requester counts.
  function automatic int unsigned idw_of(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Operand pairs whose real power is undefined (complex or infinite).
  function automatic bit pow_dom_err(real b, real e);
    return ((b < 0.0) && (e != $floor(e))) || ((b == 0.0) && (e < 0.0));
  endfunction

endpackage

// File: rtl/real_pow_sched_if.sv
// Requester-side bus of the pow scheduler: request levels, operands and completion.
interface real_pow_sched_if
  import real_pow_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = idw_of(NREQ);

  logic [NREQ-1:0] req;
  real             base [NREQ];
  real             expo [NREQ];
  logic [NREQ-1:0] ack;
  logic            busy;
  logic            done;
  logic [IDW-1:0]  done_id;
  real             result;
  logic            dom_err;

  modport master (
    output req, base, expo,
    input  ack, busy, done, done_id, result, dom_err
  );

  modport slave (
    input  req, base, expo,
    output ack, busy, done, done_id, result, dom_err
  );
endinterface

// File: rtl/real_pow_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IDW-1:0]  grant_o
);
  int unsigned idx;

  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/real_pow_sched.sv
// Shares one external real_pow evaluator among NREQ requesters, one operation per
// SETTLE+1 clocks, returning a tagged result with a domain-error qualifier.
module real_pow_sched
  import real_pow_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned IDW    = idw_of(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  real_pow_sched_if.slave   bus,
  output real               pow_in,
  output real               pow_powf,
  input  real               pow_out
);
  localparam int unsigned CW = $clog2(SETTLE + 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  wid_q, wid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic            dom_err_q, dom_err_d;
  real             result_q, result_d;
  real             pow_in_q, pow_in_d;
  real             pow_powf_q, pow_powf_d;

  logic            any;
  logic [IDW-1:0]  grant;
  real             sel_base, sel_expo;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .any_o   (any),
    .grant_o (grant)
  );

  always_comb begin
    sel_base = bus.base[grant];
    sel_expo = bus.expo[grant];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any) state_d = StRun;
      StRun:   if (cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    wid_d      = wid_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ack_d      = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    dom_err_d  = 1'b0;
    result_d   = result_q;
    pow_in_d   = pow_in_q;
    pow_powf_d = pow_powf_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          ack_d      = NREQ'(1) << grant;
          pow_in_d   = sel_base;
          pow_powf_d = sel_expo;
          wid_d      = grant;
          err_d      = pow_dom_err(sel_base, sel_expo);
          busy_d     = 1'b1;
          cnt_d      = CW'(SETTLE - 1);
          ptr_d      = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // The evaluator may produce NaN for illegal operands; never forward it.
          result_d  = err_q ? 0.0 : pow_out;
          dom_err_d = err_q;
          done_d    = 1'b1;
          done_id_d = wid_q;
          busy_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      wid_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      dom_err_q  <= 1'b0;
      result_q   <= 0.0;
      pow_in_q   <= 0.0;
      pow_powf_q <= 0.0;
    end else begin
      ptr_q      <= ptr_d;
      wid_q      <= wid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      dom_err_q  <= dom_err_d;
      result_q   <= result_d;
      pow_in_q   <= pow_in_d;
      pow_powf_q <= pow_powf_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.dom_err = dom_err_q;
  assign bus.result  = result_q;
  assign pow_in      = pow_in_q;
  assign pow_powf    = pow_powf_q;
endmodule

// File: tb/tb_real_pow_sched.sv
// Bench for real_pow_sched: table-driven single ops, contention, late arrival,
// abort by reset, and a SETTLE=1 build, with a completion scoreboard.
module tb_real_pow_sched;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned SETTLE = 2;

  typedef struct {
    int  id;
    real res;
    bit  err;
  } exp_t;

  typedef struct {
    int  id;
    real b;
    real e;
    real r;
    bit  err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];

  real pow_in, pow_powf, pow_out;
  real pow1_in, pow1_powf, pow1_out;

  real_pow_sched_if #(.NREQ(NREQ)) bus ();
  real_pow_sched_if #(.NREQ(NREQ)) bus1 ();

  real_pow_sched #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pow_in   (pow_in),
    .pow_powf (pow_powf),
    .pow_out  (pow_out)
  );

  real_pow_sched #(.NREQ(NREQ), .SETTLE(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus1),
    .pow_in   (pow1_in),
    .pow_powf (pow1_powf),
    .pow_out  (pow1_out)
  );

  // Stand-in for the external real_pow evaluator.
  always_comb pow_out  = $pow(pow_in, pow_powf);
  always_comb pow1_out = $pow(pow1_in, pow1_powf);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk_int(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_real(string name, real act, real exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %f, expected %f", name, act, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expected entry.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk_int("unexpected done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk_int("done_id", longint'(bus.done_id), mon_e.id);
        chk_real("result", bus.result, mon_e.res);
        chk_int("dom_err", longint'(bus.dom_err), longint'(mon_e.err));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(int g, string name);
    bit got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack != '0) got = 1'b1;
    end
    if (!got) chk_int({name, " ack timeout"}, 0, 1);
    else      chk_int({name, " ack"}, longint'(bus.ack), longint'(1) << g);
    bus.req[g] = 1'b0;
  endtask

  task automatic do_op(vec_t v);
    @(negedge clk);
    bus.req       = '0;
    bus.req[v.id] = 1'b1;
    bus.base[v.id] = v.b;
    bus.expo[v.id] = v.e;
    sb_q.push_back('{v.id, v.r, v.err});
    @(posedge clk);
    #1;
    chk_int("op ack", longint'(bus.ack), longint'(1) << v.id);
    chk_int("op busy", longint'(bus.busy), 1);
    bus.req[v.id] = 1'b0;
    for (int k = 0; k < SETTLE; k++) begin
      @(posedge clk);
      #1;
      chk_int("op done timing", longint'(bus.done), (k == SETTLE - 1) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk_int("done pulse width", longint'(bus.done), 0);
    chk_int("busy after done", longint'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  last;
    int  g;
    bit  seen;

    vecs[0] = '{1, 2.0, 10.0, 1024.0, 1'b0};
    vecs[1] = '{0, -8.0, 0.5, 0.0, 1'b1};
    vecs[2] = '{2, 0.0, -1.0, 0.0, 1'b1};
    vecs[3] = '{3, -2.0, 3.0, -8.0, 1'b0};
    vecs[4] = '{1, 3.0, 2.0, 9.0, 1'b0};
    vecs[5] = '{0, 0.0, 0.0, 1.0, 1'b0};
    vecs[6] = '{2, -4.0, 2.0, 16.0, 1'b0};
    vecs[7] = '{3, 16.0, 0.5, 4.0, 1'b0};

    bus.req  = '0;
    bus1.req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("reset ack", longint'(bus.ack), 0);
    chk_int("reset busy", longint'(bus.busy), 0);
    chk_int("reset done", longint'(bus.done), 0);
    chk_int("reset done_id", longint'(bus.done_id), 0);
    chk_int("reset dom_err", longint'(bus.dom_err), 0);
    chk_real("reset result", bus.result, 0.0);
    chk_real("reset pow_in", pow_in, 0.0);
    chk_real("reset pow_powf", pow_powf, 0.0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with no request: nothing moves.
    repeat (3) @(posedge clk);
    #1;
    chk_int("idle busy", longint'(bus.busy), 0);

    foreach (vecs[i]) do_op(vecs[i]);
    chk_real("pow_in holds in idle", pow_in, 16.0);

    // Contention: all four held, each re-raised after its ack.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.base[i] = real'(i + 1);
      bus.expo[i] = 2.0;
    end
    for (int n = 0; n < 8; n++) sb_q.push_back('{n % NREQ, real'((n % NREQ + 1) ** 2), 1'b0});
    bus.req = '1;
    last = 0;
    for (int n = 0; n < 8; n++) begin
      g = n % NREQ;
      wait_ack(g, "contention");
      if (n > 0) chk_int("grant spacing", cyc - last, SETTLE + 1);
      last = cyc;
      @(negedge clk);
      if (n < 7) bus.req[g] = 1'b1;
      else       bus.req = '0;
    end
    repeat (SETTLE + 2) @(posedge clk);

    // Late arrival during RUN is ignored until the next IDLE edge.
    do_reset();
    @(negedge clk);
    bus.base[2] = 5.0;  bus.expo[2] = 1.0;
    bus.base[3] = 2.0;  bus.expo[3] = 3.0;
    bus.base[0] = 7.0;  bus.expo[0] = 1.0;
    sb_q.push_back('{2, 5.0, 1'b0});
    sb_q.push_back('{3, 8.0, 1'b0});
    sb_q.push_back('{0, 7.0, 1'b0});
    bus.req[2] = 1'b1;
    wait_ack(2, "late first");
    @(negedge clk);
    bus.req[0] = 1'b1;
    bus.req[3] = 1'b1;
    @(posedge clk);
    #1;
    chk_int("late req ignored", longint'(bus.ack), 0);
    wait_ack(3, "late second");
    wait_ack(0, "late third");
    repeat (SETTLE + 2) @(posedge clk);

    // Reset one edge after grant aborts the operation.
    do_reset();
    @(negedge clk);
    bus.base[1] = 2.0;  bus.expo[1] = 5.0;
    bus.base[2] = 10.0; bus.expo[2] = 2.0;
    bus.req[1] = 1'b1;
    wait_ack(1, "abort");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_int("abort busy", longint'(bus.busy), 0);
    chk_int("abort ack", longint'(bus.ack), 0);
    chk_real("abort pow_in", pow_in, 0.0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    chk_int("no done after abort", longint'(seen), 0);
    @(negedge clk);
    sb_q.push_back('{1, 32.0, 1'b0});
    sb_q.push_back('{2, 100.0, 1'b0});
    bus.req = 4'b0110;
    wait_ack(1, "post-abort first");
    wait_ack(2, "post-abort second");
    repeat (SETTLE + 2) @(posedge clk);

    // SETTLE=1 build.
    @(negedge clk);
    bus1.base[0] = 3.0;
    bus1.expo[0] = 2.0;
    bus1.req[0]  = 1'b1;
    @(posedge clk);
    #1;
    chk_int("s1 ack", longint'(bus1.ack), 1);
    chk_int("s1 done early", longint'(bus1.done), 0);
    bus1.req[0] = 1'b0;
    @(posedge clk);
    #1;
    chk_int("s1 done", longint'(bus1.done), 1);
    chk_real("s1 result", bus1.result, 9.0);
    chk_int("s1 done_id", longint'(bus1.done_id), 0);
    chk_int("s1 busy", longint'(bus1.busy), 0);
    @(posedge clk);
    #1;
    chk_int("s1 done pulse", longint'(bus1.done), 0);

    chk_int("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
